// File: rtl/gpr_pkg.sv
// Shared types for the GPR write-port arbiter: request record, grant source, null test.
// Widths here must agree with the arbiter's DATA_WIDTH/ADDR_WIDTH parameters.
package gpr_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [3:0]            byte_en;
   } wr_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_A,
      GNT_B
   } grant_src_t;

   // A request that would not change the register file is dropped at acceptance.
   function automatic logic is_null(input wr_req_t r);
      return (r.addr == '0) || (r.byte_en == '0);
   endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Small circular FIFO holding queued MDU writes; exposes every slot's valid/addr
// so the arbiter can answer hazard lookups against not-yet-retired writes.
module gpr_wb_fifo
   import gpr_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push,
   input  wr_req_t                          push_req,
   input  logic                             pop,
   output wr_req_t                          head,
   output logic [CW-1:0]                    count,
   output logic                             full,
   output logic                             empty,
   output logic [DEPTH-1:0]                 ent_valid,
   output logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr
);

   wr_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: occupancy is tracked entirely by the pointers/count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= push_req;
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         int offset;
         // Distance of this slot from the head; live if inside the occupied span.
         always_comb begin
            offset = (gi >= int'(rd_ptr_reg)) ? gi - int'(rd_ptr_reg)
                                              : gi + DEPTH - int'(rd_ptr_reg);
         end
         assign ent_valid[gi] = (offset < int'(count_reg));
         assign ent_addr[gi]  = mem[gi].addr;
      end
   endgenerate

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between writeback (A) and the MDU (B),
// with a queue for B, a starvation bound on B, and pending-write hazard lookups.
module gpr_wb_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int B_DEPTH      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [3:0]            a_byte_en,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   input  logic [3:0]            b_byte_en,
   output logic                  gpr_write,
   output logic [ADDR_WIDTH-1:0] gpr_rd_addr,
   output logic [DATA_WIDTH-1:0] gpr_rd_in,
   output logic [3:0]            gpr_byte_w_en,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   output logic                  rs_pending,
   output logic                  rt_pending
);

   import gpr_pkg::*;

   localparam int CW = $clog2(B_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wr_req_t                            a_req;
   wr_req_t                            b_req;
   wr_req_t                            fifo_head;
   wr_req_t                            out_req_reg;
   logic                               gpr_write_reg;
   logic [SW-1:0]                      starve_cnt_reg;
   logic [SW-1:0]                      starve_cnt_next;
   logic [CW-1:0]                      fifo_count;
   logic                               fifo_full;
   logic                               fifo_empty;
   logic [B_DEPTH-1:0]                 ent_valid;
   logic [B_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
   logic                               forced;
   logic                               b_push;
   logic                               b_pop;
   grant_src_t                         grant;

   assign a_req = '{a_addr, a_data, a_byte_en};
   assign b_req = '{b_addr, b_data, b_byte_en};

   // Everything below depends only on registered state, so readies never loop back.
   assign forced  = !fifo_empty && (starve_cnt_reg == SW'(STARVE_LIMIT));
   assign a_ready = !forced;
   assign b_ready = (fifo_count < CW'(B_DEPTH));

   always_comb begin
      grant = GNT_NONE;
      if (forced)
         grant = GNT_B;
      else if (a_valid && !is_null(a_req))
         grant = GNT_A;
      else if (!fifo_empty)
         grant = GNT_B;
   end

   assign b_push = b_valid && !fifo_full && !is_null(b_req);
   assign b_pop  = (grant == GNT_B);

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (fifo_empty || grant == GNT_B)
         starve_cnt_next = '0;
      else if (starve_cnt_reg != SW'(STARVE_LIMIT))
         starve_cnt_next = starve_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_reg <= '0;
         gpr_write_reg  <= 1'b0;
         out_req_reg    <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         gpr_write_reg  <= (grant != GNT_NONE);
         case (grant)
            GNT_A:   out_req_reg <= a_req;
            GNT_B:   out_req_reg <= fifo_head;
            default: out_req_reg <= out_req_reg;
         endcase
      end
   end

   gpr_wb_fifo #(
      .DEPTH(B_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (b_push),
      .push_req (b_req),
      .pop      (b_pop),
      .head     (fifo_head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .ent_valid(ent_valid),
      .ent_addr (ent_addr)
   );

   assign gpr_write     = gpr_write_reg;
   assign gpr_rd_addr   = out_req_reg.addr;
   assign gpr_rd_in     = out_req_reg.data;
   assign gpr_byte_w_en = out_req_reg.byte_en;

   logic [B_DEPTH-1:0] rs_hit;
   logic [B_DEPTH-1:0] rt_hit;

   generate
      for (genvar gi = 0; gi < B_DEPTH; gi++) begin : g_hit
         assign rs_hit[gi] = ent_valid[gi] && (ent_addr[gi] == rs_addr);
         assign rt_hit[gi] = ent_valid[gi] && (ent_addr[gi] == rt_addr);
      end
   endgenerate

   // An issuing write still counts as pending until its gpr_write cycle ends.
   assign rs_pending = (rs_addr != '0) &&
                       ((|rs_hit) || (gpr_write_reg && out_req_reg.addr == rs_addr));
   assign rt_pending = (rt_addr != '0) &&
                       ((|rt_hit) || (gpr_write_reg && out_req_reg.addr == rt_addr));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: table of A-only vectors plus hand-built multi-cycle
// sequences; every expected GPR write is queued with the cycle it must appear in.
module tb_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, a_ready;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic [3:0]  a_byte_en;
   logic        b_valid, b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic [3:0]  b_byte_en;
   logic        gpr_write;
   logic [4:0]  gpr_rd_addr;
   logic [31:0] gpr_rd_in;
   logic [3:0]  gpr_byte_w_en;
   logic [4:0]  rs_addr, rt_addr;
   logic        rs_pending, rt_pending;

   always #5 clk = ~clk;

   gpr_wb_arbiter #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .B_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .a_byte_en(a_byte_en),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .b_byte_en(b_byte_en),
      .gpr_write(gpr_write), .gpr_rd_addr(gpr_rd_addr), .gpr_rd_in(gpr_rd_in),
      .gpr_byte_w_en(gpr_byte_w_en),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_pending(rs_pending), .rt_pending(rt_pending)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          due;
   } exp_wr_t;

   typedef struct {
      logic        v;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        exp_wr;
   } vec_t;

   exp_wr_t sb[$];
   exp_wr_t mon_e;
   vec_t    vecs[6];
   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc      = 0;
   int      k;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int due);
      exp_wr_t e;
      e.addr = a; e.data = d; e.be = be; e.due = due;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; a_addr = '0; a_data = '0; a_byte_en = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0; b_byte_en = '0;
   endtask

   // Write monitor: each issued write must match the next queued expectation.
   always @(negedge clk) begin
      if (gpr_write === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h at cycle %0d, required no write",
                     gpr_rd_addr, gpr_rd_in, cyc);
         end else begin
            mon_e = sb.pop_front();
            $display("write cycle %0d addr %0d data 0x%08h be 0x%0h", cyc, gpr_rd_addr,
                     gpr_rd_in, gpr_byte_w_en);
            chk("wr_addr", 64'(gpr_rd_addr), 64'(mon_e.addr));
            chk("wr_data", 64'(gpr_rd_in), 64'(mon_e.data));
            chk("wr_be", 64'(gpr_byte_w_en), 64'(mon_e.be));
            chk("wr_cycle", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 1'b1};
      vecs[1] = '{1'b1, 5'd0,  32'h11111111, 4'hF, 1'b0};
      vecs[2] = '{1'b1, 5'd9,  32'h22222222, 4'h0, 1'b0};
      vecs[3] = '{1'b0, 5'd4,  32'h33333333, 4'hF, 1'b0};
      vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 4'h3, 1'b1};
      vecs[5] = '{1'b1, 5'd1,  32'h00000BAD, 4'h8, 1'b1};

      reset = 1'b1;
      idle_inputs();
      rs_addr = 5'd3;
      rt_addr = 5'd7;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_gpr_write", 64'(gpr_write), 64'd0);
      chk("rst_rd_addr", 64'(gpr_rd_addr), 64'd0);
      chk("rst_rd_in", 64'(gpr_rd_in), 64'd0);
      chk("rst_be", 64'(gpr_byte_w_en), 64'd0);
      chk("rst_a_ready", 64'(a_ready), 64'd1);
      chk("rst_b_ready", 64'(b_ready), 64'd1);
      chk("rst_rs_pending", 64'(rs_pending), 64'd0);
      chk("rst_rt_pending", 64'(rt_pending), 64'd0);

      // A-only table, including null and idle vectors
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a_valid = vecs[i].v; a_addr = vecs[i].addr;
         a_data = vecs[i].data; a_byte_en = vecs[i].be;
         #1;
         chk("tbl_a_ready", 64'(a_ready), 64'd1);
         if (vecs[i].exp_wr) expect_wr(vecs[i].addr, vecs[i].data, vecs[i].be, cyc + 1);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      #1;
      chk("hold_write", 64'(gpr_write), 64'd0);
      chk("hold_addr", 64'(gpr_rd_addr), 64'd1);
      chk("hold_data", 64'(gpr_rd_in), 64'h0BAD);

      // B behind a continuous A stream: four lost cycles, then forced grant
      k = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_addr = 5'(10 + k); a_data = 32'hA000 + 32'(k); a_byte_en = 4'hF;
         b_valid = (i == 0); b_addr = 5'd7; b_data = 32'h12345678; b_byte_en = 4'hF;
         #1;
         chk("starve_a_ready", 64'(a_ready), 64'(i != 5));
         if (i == 5) expect_wr(5'd7, 32'h12345678, 4'hF, cyc + 1);
         else begin
            expect_wr(5'(10 + k), 32'hA000 + 32'(k), 4'hF, cyc + 1);
            k++;
         end
      end
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);

      // Fill the FIFO while A keeps winning; watch b_ready and pending lookups
      rs_addr = 5'd7;
      rt_addr = 5'd8;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_addr = 5'(16 + k); a_data = 32'hB000 + 32'(k); a_byte_en = 4'hF;
         b_valid = (i < 2); b_addr = (i == 0) ? 5'd7 : 5'd8;
         b_data = (i == 0) ? 32'h77 : 32'h88; b_byte_en = 4'hF;
         #1;
         chk("fill_a_ready", 64'(a_ready), 64'(i != 5 && i != 10));
         chk("fill_b_ready", 64'(b_ready), 64'(!(i >= 2 && i <= 5)));
         chk("fill_rs_pending", 64'(rs_pending), 64'(i >= 1 && i <= 6));
         chk("fill_rt_pending", 64'(rt_pending), 64'(i >= 2 && i <= 11));
         if (i == 5) expect_wr(5'd7, 32'h77, 4'hF, cyc + 1);
         else if (i == 10) expect_wr(5'd8, 32'h88, 4'hF, cyc + 1);
         else begin
            expect_wr(5'(16 + k), 32'hB000 + 32'(k), 4'hF, cyc + 1);
            k++;
         end
      end
      @(negedge clk);
      idle_inputs();
      rs_addr = '0;
      @(negedge clk);

      // Null requests: both accepted, nothing issued or queued
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD; a_byte_en = 4'hF;
      b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99; b_byte_en = 4'h0;
      #1;
      chk("null_a_ready", 64'(a_ready), 64'd1);
      chk("null_b_ready", 64'(b_ready), 64'd1);
      @(negedge clk);
      idle_inputs();
      rt_addr = 5'd9;
      #1;
      chk("null_no_write", 64'(gpr_write), 64'd0);
      chk("null_not_queued", 64'(rt_pending), 64'd0);
      chk("null_b_ready_after", 64'(b_ready), 64'd1);
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2222; a_byte_en = 4'hF;
      b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6666; b_byte_en = 4'hF;
      expect_wr(5'd2, 32'h2222, 4'hF, cyc + 1);
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF; a_byte_en = 4'hF;
      b_valid = 1'b0;
      expect_wr(5'd6, 32'h6666, 4'hF, cyc + 1);
      @(negedge clk);
      idle_inputs();
      rt_addr = '0;
      @(negedge clk);

      // Same-address collision: A first, then B overwrites
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1; a_byte_en = 4'hF;
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h2; b_byte_en = 4'hF;
      expect_wr(5'd5, 32'h1, 4'hF, cyc + 1);
      expect_wr(5'd5, 32'h2, 4'hF, cyc + 2);
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);

      // Reset with FIFO full and a write on the port: everything in flight discarded
      rs_addr = 5'd11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_addr = 5'(20 + i); a_data = 32'hC000 + 32'(i); a_byte_en = 4'hF;
         b_valid = (i < 2); b_addr = 5'(11 + i); b_data = 32'hB1 + 32'(i); b_byte_en = 4'hF;
         expect_wr(5'(20 + i), 32'hC000 + 32'(i), 4'hF, cyc + 1);
         if (i == 2) begin
            #1;
            chk("prerst_b_ready", 64'(b_ready), 64'd0);
            chk("prerst_rs_pending", 64'(rs_pending), 64'd1);
         end
      end
      @(negedge clk);
      chk("prerst_gpr_write", 64'(gpr_write), 64'd1);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      #1;
      chk("midrst_gpr_write", 64'(gpr_write), 64'd0);
      chk("midrst_rd_addr", 64'(gpr_rd_addr), 64'd0);
      chk("midrst_rd_in", 64'(gpr_rd_in), 64'd0);
      chk("midrst_be", 64'(gpr_byte_w_en), 64'd0);
      chk("midrst_b_ready", 64'(b_ready), 64'd1);
      chk("midrst_a_ready", 64'(a_ready), 64'd1);
      chk("midrst_rs_pending", 64'(rs_pending), 64'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("postrst_rs_pending", 64'(rs_pending), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
